// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_e : receive deframer FSM states
//   wls_e      : word-length-select encodings (00=5 .. 11=8 bits)
//   rx_cfg_t   : frame configuration latched at each start bit
//   WLS_BASE   : data bits encoded by wls=00
//   DATA_W     : widest data word
package uart_pkg;

    localparam int WLS_BASE = 5;
    localparam int DATA_W   = 8;

    typedef enum logic [1:0] {
        WLS_5 = 2'b00,
        WLS_6 = 2'b01,
        WLS_7 = 2'b10,
        WLS_8 = 2'b11
    } wls_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    typedef struct packed {
        logic [1:0] wls;
        logic       pen;
        logic       eps;
        logic       sp;
    } rx_cfg_t;

endpackage

// File: rtl/dff.sv
// Generic resettable flop bank.
//   pclk    : clock
//   presetn : asynchronous active-low reset, loads RST_VAL
//   d / q   : W-bit data in / registered data out
module dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         pclk,
    input  logic         presetn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) q <= RST_VAL;
        else          q <= d;
    end

endmodule

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous rxd line, with an
// optional 3-sample majority filter, and falling-edge detection.
//   Build macro UART_RX_MAJORITY_EN: when defined, rxd_s is the majority of
//   three flops behind the synchronizer (rejects 1-pclk glitches, +2 cycles
//   latency); otherwise rxd_s is the synchronizer output.
//   pclk, presetn : clock, async active-low reset (all flops preset to 1)
//   rxd           : raw serial input, idle high
//   rxd_s         : synchronized (filtered) line level
//   rxd_fall      : rxd_s is 0 and was 1 on the previous cycle
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic pclk,
    input  logic presetn,
    input  logic rxd,
    output logic rxd_s,
    output logic rxd_fall
);

    logic [SYNC_STAGES-1:0] sync_d, sync_q;
    logic                   rxd_sync;
    logic                   rxd_prev_q;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], rxd};

    // Preset to 1 so reset release does not look like a start bit.
    dff #(.W(SYNC_STAGES), .RST_VAL({SYNC_STAGES{1'b1}})) u_sync (
        .pclk    (pclk),
        .presetn (presetn),
        .d       (sync_d),
        .q       (sync_q)
    );

    assign rxd_sync = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    logic [2:0] maj_d, maj_q;

    assign maj_d = {maj_q[1:0], rxd_sync};

    dff #(.W(3), .RST_VAL(3'b111)) u_maj (
        .pclk    (pclk),
        .presetn (presetn),
        .d       (maj_d),
        .q       (maj_q)
    );

    assign rxd_s = (maj_q[0] & maj_q[1]) | (maj_q[0] & maj_q[2]) | (maj_q[1] & maj_q[2]);
`else
    assign rxd_s = rxd_sync;
`endif

    dff #(.W(1), .RST_VAL(1'b1)) u_prev (
        .pclk    (pclk),
        .presetn (presetn),
        .d       (rxd_s),
        .q       (rxd_prev_q)
    );

    assign rxd_fall = rxd_prev_q & ~rxd_s;

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: turns the serial rxd stream (start, 5-8 data bits
// LSB first, optional parity, stop) into a parallel word plus error flags.
//   Build macro UART_RX_MAJORITY_EN enables the majority filter in uart_rx_sync.
//   pclk, presetn  : clock, async active-low reset
//   rxd            : serial input, idle high
//   sample_edge    : mid-bit pulse from the baud/sample generator
//   wls/pen/eps/sp : word length, parity enable, even parity, stick parity
//   sample_clk_clr : 1-cycle pulse realigning the sample counter on a start bit
//   rx_push        : 1-cycle pulse, rx_data/rx_pe/rx_fe/rx_bi valid (held until next push)
//   rx_busy        : FSM not in IDLE
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              rxd,
    input  logic              sample_edge,
    input  logic [1:0]        wls,
    input  logic              pen,
    input  logic              eps,
    input  logic              sp,
    output logic              sample_clk_clr,
    output logic              rx_push,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_pe,
    output logic              rx_fe,
    output logic              rx_bi,
    output logic              rx_busy
);

    logic rxd_s, rxd_fall;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .pclk     (pclk),
        .presetn  (presetn),
        .rxd      (rxd),
        .rxd_s    (rxd_s),
        .rxd_fall (rxd_fall)
    );

    rx_state_e         state_q, state_d;
    rx_cfg_t           cfg_q, cfg_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              clr_q, clr_d;
    logic              push_q, push_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              pe_q, pe_d;
    logic              fe_q, fe_d;
    logic              bi_q, bi_d;
    logic              par_exp;

    // Inactive upper bits of shift_q are cleared at frame start, so a
    // whole-word reduction gives the parity of the active bits only.
    assign par_exp = cfg_q.sp  ? ~cfg_q.eps :
                     cfg_q.eps ? ^shift_q   : ~(^shift_q);

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        clr_d     = 1'b0;
        push_d    = 1'b0;
        data_d    = data_q;
        pe_d      = pe_q;
        fe_d      = fe_q;
        bi_d      = bi_q;
        case (state_q)
            ST_IDLE: begin
                if (rxd_fall) begin
                    clr_d     = 1'b1;
                    cfg_d     = '{wls: wls, pen: pen, eps: eps, sp: sp};
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    par_d     = 1'b0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                // A sample_edge coincident with the counter clear is stale.
                if (sample_edge && !clr_q)
                    state_d = rxd_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (sample_edge) begin
                    shift_d[bit_cnt_q] = rxd_s;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == {1'b0, cfg_q.wls} + 3'(WLS_BASE - 1))
                        state_d = cfg_q.pen ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (sample_edge) begin
                    par_d   = rxd_s;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample_edge) begin
                    push_d  = 1'b1;
                    data_d  = shift_q;
                    pe_d    = cfg_q.pen & (par_q != par_exp);
                    fe_d    = ~rxd_s;
                    bi_d    = ~rxd_s & (shift_q == '0) & ~(cfg_q.pen & par_q);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= ST_IDLE;
            cfg_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            clr_q     <= 1'b0;
            push_q    <= 1'b0;
            data_q    <= '0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            bi_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            clr_q     <= clr_d;
            push_q    <= push_d;
            data_q    <= data_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            bi_q      <= bi_d;
        end
    end

    assign sample_clk_clr = clr_q;
    assign rx_push        = push_q;
    assign rx_data        = data_q;
    assign rx_pe          = pe_q;
    assign rx_fe          = fe_q;
    assign rx_bi          = bi_q;
    assign rx_busy        = (state_q != ST_IDLE);

endmodule
